// File: rtl/dram_cmd_responder.sv
// Device-side DRAM command responder: accepts ACT/RD/WR/REF over a 4-phase req/ack
// handshake, tracks open rows per bank and returns cmd_ack after timing-accurate latency.
module dram_cmd_responder #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int T_RCD           = 3,
  parameter int T_RP            = 3,
  parameter int T_CL            = 2,
  parameter int T_RFC           = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_req,
  input  logic [1:0]                          cmd,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0]  bank_rw,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]   row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]   col_id,
  output logic                                cmd_ack,
  output logic                                busy,
  output logic                                row_hit,
  output logic                                err,
  output logic                                rd_done,
  output logic [NUMBER_OF_BANKS-1:0]          open_bank_mask
);

  localparam int BW     = $clog2(NUMBER_OF_BANKS);
  localparam int RW     = $clog2(NUMBER_OF_ROWS);
  localparam int MISS_L = T_RP + T_RCD;
  localparam int MAX_A  = (MISS_L > T_RFC) ? MISS_L : T_RFC;
  localparam int MAX_L  = (MAX_A > T_CL) ? MAX_A : T_CL;
  localparam int CNTW   = $clog2(MAX_L + 1);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e               state_q;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [1:0]           cmd_q;
  logic [BW-1:0]        bank_q;
  logic [RW-1:0]        row_q;
  logic                 hit_q, hit_d;
  logic                 acc_err_q, acc_err_d;
  logic [NUMBER_OF_BANKS-1:0] open_q;
  logic [RW-1:0]        row_tbl_q [NUMBER_OF_BANKS];
  logic                 bank_open;

  // Column addresses carry no state in this model; they wrap freely in CW bits.
  logic unused_col;
  assign unused_col = ^col_id;

  assign open_bank_mask = open_q;

  // Latency (minus one) is decided from the bank state seen at acceptance.
  always_comb begin
    bank_open = open_q[bank_rw];
    hit_d     = 1'b0;
    acc_err_d = 1'b0;
    cnt_d     = CNTW'(T_CL - 1);
    case (cmd)
      CMD_ACT: begin
        if (!bank_open) begin
          cnt_d = CNTW'(T_RCD - 1);
        end else if (row_tbl_q[bank_rw] == row_id) begin
          hit_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = CNTW'(MISS_L - 1);
        end
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open) begin
          acc_err_d = 1'b1;
          cnt_d     = '0;
        end
      end
      default: cnt_d = CNTW'(T_RFC - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cmd_req) begin
      cmd_q     <= cmd;
      bank_q    <= bank_rw;
      row_q     <= row_id;
      hit_q     <= hit_d;
      acc_err_q <= acc_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_ack <= 1'b0;
      busy    <= 1'b0;
      row_hit <= 1'b0;
      err     <= 1'b0;
      rd_done <= 1'b0;
      open_q  <= '0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) row_tbl_q[b] <= '0;
    end else begin
      err     <= 1'b0;
      rd_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_req) begin
            cnt_q   <= cnt_d;
            busy    <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            cmd_ack <= 1'b1;
            row_hit <= hit_q;
            err     <= acc_err_q;
            rd_done <= (cmd_q == CMD_RD) && !acc_err_q;
            state_q <= S_ACK;
            if (cmd_q == CMD_ACT) begin
              open_q[bank_q]    <= 1'b1;
              row_tbl_q[bank_q] <= row_q;
            end else if (cmd_q == 2'b11) begin
              open_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACK: begin
          if (!cmd_req) begin
            cmd_ack <= 1'b0;
            busy    <= 1'b0;
            row_hit <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: directed vector table, hand-written reset sequences,
// and randomized commands checked against a bank/row reference model.
module tb_dram_cmd_responder;
  localparam int NB = 8;
  localparam int T_RCD = 3, T_RP = 3, T_CL = 2, T_RFC = 8;

  logic clk = 1'b0;
  logic rst, cmd_req;
  logic [1:0] cmd;
  logic [2:0] bank_rw;
  logic [6:0] row_id;
  logic [2:0] col_id;
  logic cmd_ack, busy, row_hit, err, rd_done;
  logic [7:0] open_bank_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_cmd_responder dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd), .bank_rw(bank_rw),
    .row_id(row_id), .col_id(col_id), .cmd_ack(cmd_ack), .busy(busy),
    .row_hit(row_hit), .err(err), .rd_done(rd_done), .open_bank_mask(open_bank_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which banks are open and which row each holds.
  bit m_open[NB];
  int m_row[NB];

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin m_open[b] = 0; m_row[b] = 0; end
  endtask

  function automatic logic [7:0] model_mask();
    logic [7:0] m = '0;
    for (int b = 0; b < NB; b++) m[b] = m_open[b];
    return m;
  endfunction

  task automatic model_cmd(input int c, input int b, input int r,
                           output int lat, output bit hit, output bit e, output bit rd);
    hit = 0; e = 0; rd = 0; lat = 0;
    if (c == 0) begin
      if (!m_open[b]) lat = T_RCD;
      else if (m_row[b] == r) begin lat = 1; hit = 1; end
      else lat = T_RP + T_RCD;
      m_open[b] = 1;
      m_row[b]  = r;
    end else if (c == 1 || c == 2) begin
      if (m_open[b]) begin lat = T_CL; rd = (c == 1); end
      else begin lat = 1; e = 1; end
    end else begin
      lat = T_RFC;
      for (int i = 0; i < NB; i++) m_open[i] = 0;
    end
  endtask

  // Issue one command; drop_at>0 lowers cmd_req before the drop_at-th edge after acceptance.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [2:0] b,
                         input logic [6:0] r, input logic [2:0] col, input int drop_at,
                         input int exp_lat, input bit exp_hit, input bit exp_err,
                         input bit exp_rd, input logic [7:0] exp_mask);
    int lat;
    bit got;
    logic hit_s, err_s, rd_s;
    logic [7:0] mask_s;
    lat = 0; got = 0; hit_s = 0; err_s = 0; rd_s = 0; mask_s = '0;
    cmd_req = 1'b1; cmd = c; bank_rw = b; row_id = r; col_id = col;
    @(posedge clk); #1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 40 && !got; k++) begin
      cmd = 2'($urandom); bank_rw = 3'($urandom); row_id = 7'($urandom); col_id = 3'($urandom);
      if (k == drop_at) cmd_req = 1'b0;
      @(posedge clk); #1;
      if (cmd_ack) begin
        got = 1; lat = k;
        hit_s = row_hit; err_s = err; rd_s = rd_done; mask_s = open_bank_mask;
      end
    end
    if (!got) begin
      chk({tag, " ack timeout"}, 32'd0, 32'd1);
      cmd_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " row_hit"}, 32'(hit_s), 32'(exp_hit));
    chk({tag, " err"}, 32'(err_s), 32'(exp_err));
    chk({tag, " rd_done"}, 32'(rd_s), 32'(exp_rd));
    chk({tag, " mask"}, 32'(mask_s), 32'(exp_mask));
    if (cmd_req) begin
      @(posedge clk); #1;
      chk({tag, " ack hold"}, 32'(cmd_ack), 32'd1);
      chk({tag, " pulse width"}, 32'(err | rd_done), 32'd0);
      cmd_req = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " ack fall"}, 32'(cmd_ack), 32'd0);
    chk({tag, " busy fall"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0] c; logic [2:0] b; logic [6:0] r; logic [2:0] col;
    int drop; int lat; bit hit; bit e; bit rd; logic [7:0] mask;
  } vec_t;

  vec_t tbl[11];

  task automatic do_reset();
    rst = 1'b1; cmd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cmd_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit hit, e, rd, ack_seen;
    int c, b, r, drop;

    tbl[0]  = '{2'd0, 3'd3, 7'd17, 3'd0, 0, 3, 1'b1 & 1'b0, 0, 0, 8'h08};
    tbl[1]  = '{2'd0, 3'd3, 7'd17, 3'd0, 0, 1, 1, 0, 0, 8'h08};
    tbl[2]  = '{2'd0, 3'd3, 7'd40, 3'd0, 0, 6, 0, 0, 0, 8'h08};
    tbl[3]  = '{2'd1, 3'd5, 7'd0,  3'd2, 0, 1, 0, 1, 0, 8'h08};
    tbl[4]  = '{2'd1, 3'd3, 7'd0,  3'd4, 0, 2, 0, 0, 1, 8'h08};
    tbl[5]  = '{2'd0, 3'd6, 7'd5,  3'd0, 0, 3, 0, 0, 0, 8'h48};
    tbl[6]  = '{2'd2, 3'd6, 7'd0,  3'd7, 0, 2, 0, 0, 0, 8'h48};
    tbl[7]  = '{2'd3, 3'd0, 7'd0,  3'd0, 0, 8, 0, 0, 0, 8'h00};
    tbl[8]  = '{2'd0, 3'd6, 7'd9,  3'd0, 0, 3, 0, 0, 0, 8'h40};
    tbl[9]  = '{2'd3, 3'd0, 7'd0,  3'd0, 6, 8, 0, 0, 0, 8'h00};
    tbl[10] = '{2'd2, 3'd0, 7'd0,  3'd1, 0, 1, 0, 1, 0, 8'h00};

    rst = 1'b1; cmd_req = 1'b0; cmd = '0; bank_rw = '0; row_id = '0; col_id = '0;

    // Reset held with cmd_req asserted: nothing may start.
    rst = 1'b1; cmd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'({cmd_ack, busy, row_hit, err, rd_done}), 32'd0);
    chk("reset mask", 32'(open_bank_mask), 32'd0);
    rst = 1'b0; cmd_req = 1'b0;
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].r, tbl[i].col, tbl[i].drop,
              tbl[i].lat, tbl[i].hit, tbl[i].e, tbl[i].rd, tbl[i].mask);

    // Reset during WAIT aborts the command and clears bank state.
    run_cmd("pre-abort act", 2'd0, 3'd3, 7'd1, 3'd0, 0, 3, 0, 0, 0, 8'h08);
    cmd_req = 1'b1; cmd = 2'd0; bank_rw = 3'd1; row_id = 7'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort mask", 32'(open_bank_mask), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    rst = 1'b0; cmd_req = 1'b0;
    ack_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cmd_ack || busy) ack_seen = 1;
    end
    chk("abort no ack", 32'(ack_seen), 32'd0);
    run_cmd("post-abort act", 2'd0, 3'd1, 7'd9, 3'd0, 0, 3, 0, 0, 0, 8'h02);

    // Randomized commands against the reference model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      c = $urandom_range(0, 3);
      if (c == 3 && $urandom_range(0, 3) != 0) c = 0;
      b = $urandom_range(0, NB - 1);
      r = $urandom_range(0, 3);
      model_cmd(c, b, r, lat, hit, e, rd);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      run_cmd($sformatf("rnd%0d", n), 2'(c), 3'(b), 7'(r), 3'($urandom), drop,
              lat, hit, e, rd, model_mask());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
